conv_kernel_ctrl: RTL and testbench

//  Owns the NxN signed coefficient set driven into the convolution datapath's kernel input.

---
 rtl/conv_pkg.sv | 59 +++++
 rtl/conv_frame_counter.sv | 50 +++++
 rtl/conv_kernel_ctrl.sv | 138 +++++++++++++
 tb/tb_conv_kernel_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, sizes and coefficient presets for the kernel controller
package conv_pkg;

  localparam int SIZE                = 3;
  localparam int KERNEL_WIDTH        = 8;
  localparam int DEFAULT_LINE_WIDTH  = 640;
  localparam int DEFAULT_FRAME_LINES = 480;
  localparam int RESET_CENTER        = 1;
  localparam int NTAPS               = SIZE * SIZE;
  localparam int ADDR_W              = $clog2(NTAPS);

  // kernel[row][col] is one signed coefficient
  typedef logic signed [0:SIZE-1][0:SIZE-1][KERNEL_WIDTH-1:0] kernel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SWAP = 2'd2
  } ctrl_state_e;

  localparam logic signed [KERNEL_WIDTH-1:0] K0  = KERNEL_WIDTH'(0);
  localparam logic signed [KERNEL_WIDTH-1:0] KP1 = KERNEL_WIDTH'(1);
  localparam logic signed [KERNEL_WIDTH-1:0] KM1 = KERNEL_WIDTH'(-1);
  localparam logic signed [KERNEL_WIDTH-1:0] KP2 = KERNEL_WIDTH'(2);
  localparam logic signed [KERNEL_WIDTH-1:0] KM2 = KERNEL_WIDTH'(-2);
  localparam logic signed [KERNEL_WIDTH-1:0] KM4 = KERNEL_WIDTH'(-4);

  // 3x3 presets, row-major: identity, box, Sobel-X, Laplacian
  localparam logic signed [KERNEL_WIDTH-1:0] PRESET_TAPS [4][9] = '{
    '{K0,  K0,  K0,  K0,  KP1, K0,  K0,  K0,  K0 },
    '{KP1, KP1, KP1, KP1, KP1, KP1, KP1, KP1, KP1},
    '{KM1, K0,  KP1, KM2, K0,  KP2, KM1, K0,  KP1},
    '{K0,  KP1, K0,  KP1, KM4, KP1, K0,  KP1, K0 }
  };

  function automatic kernel_t reset_kernel();
    kernel_t k;
    k = '0;
    k[SIZE/2][SIZE/2] = KERNEL_WIDTH'(RESET_CENTER);
    return k;
  endfunction

  // Only identity exists for kernels other than 3x3
  function automatic kernel_t preset_kernel(input logic [1:0] sel);
    kernel_t k;
    k = '0;
    if (SIZE == 3) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          if (r * SIZE + c < 9) k[r][c] = PRESET_TAPS[sel][r * SIZE + c];
        end
      end
    end else begin
      k[SIZE/2][SIZE/2] = KP1;
    end
    return k;
  endfunction

endpackage

// File: rtl/conv_frame_counter.sv
// rtl/conv_frame_counter.sv - raster x/y counters with last-pixel detect and frame_done pulse
module conv_frame_counter #(
  parameter int LINE_WIDTH  = 640,
  parameter int FRAME_LINES = 480
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_pix_valid,
  output logic [$clog2(LINE_WIDTH)-1:0]  o_frame_x,
  output logic [$clog2(FRAME_LINES)-1:0] o_frame_y,
  output logic                           o_last,
  output logic                           o_frame_done
);

  localparam int XW = $clog2(LINE_WIDTH);
  localparam int YW = $clog2(FRAME_LINES);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_done;
  logic          w_x_end;
  logic          w_y_end;

  assign w_x_end      = (r_x == XW'(LINE_WIDTH - 1));
  assign w_y_end      = (r_y == YW'(FRAME_LINES - 1));
  assign o_last       = i_pix_valid && w_x_end && w_y_end;
  assign o_frame_x    = r_x;
  assign o_frame_y    = r_y;
  assign o_frame_done = r_done;

  // Advance the raster position on every accepted pixel; pulse frame_done after the last one
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= o_last;
      if (i_pix_valid) begin
        if (w_x_end) begin
          r_x <= '0;
          r_y <= w_y_end ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_kernel_ctrl.sv
// rtl/conv_kernel_ctrl.sv - shadow/active coefficient banks swapped at frame boundaries; CONV_KERNEL_PRESET_EN adds preset loads
module conv_kernel_ctrl
  import conv_pkg::*;
#(
  parameter int LINE_WIDTH  = DEFAULT_LINE_WIDTH,
  parameter int FRAME_LINES = DEFAULT_FRAME_LINES
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_pix_valid,
  input  logic                           i_cfg_wr_en,
  input  logic [ADDR_W-1:0]              i_cfg_addr,
  input  logic signed [KERNEL_WIDTH-1:0] i_cfg_data,
  input  logic                           i_cfg_commit,
`ifdef CONV_KERNEL_PRESET_EN
  input  logic                           i_cfg_preset_ld,
  input  logic [1:0]                     i_cfg_preset_sel,
`endif
  output logic                           o_cfg_busy,
  output logic                           o_cfg_err,
  output kernel_t                        o_kernel,
  output logic [$clog2(LINE_WIDTH)-1:0]  o_frame_x,
  output logic [$clog2(FRAME_LINES)-1:0] o_frame_y,
  output logic                           o_frame_done,
  output logic                           o_kernel_swap
);

  ctrl_state_e r_state;
  kernel_t     r_shadow;
  kernel_t     r_active;
  logic        r_pending;
  logic        r_err;
  logic        r_swap;

  kernel_t     w_load_k;
  logic        w_ld_ok;
  logic        w_ld_bad;
  logic        w_last;
  logic        w_in_frame;

  conv_frame_counter #(
    .LINE_WIDTH  (LINE_WIDTH),
    .FRAME_LINES (FRAME_LINES)
  ) u_frame_counter (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pix_valid  (i_pix_valid),
    .o_frame_x    (o_frame_x),
    .o_frame_y    (o_frame_y),
    .o_last       (w_last),
    .o_frame_done (o_frame_done)
  );

  // A frame has already started if the raster position has left (0,0)
  assign w_in_frame = (|o_frame_x) || (|o_frame_y);

  assign o_kernel      = r_active;
  assign o_cfg_busy    = r_pending;
  assign o_cfg_err     = r_err;
  assign o_kernel_swap = r_swap;

  // Decide whether this cycle updates the shadow bank, and with what contents
  always_comb begin
    w_ld_ok  = 1'b0;
    w_ld_bad = 1'b0;
    w_load_k = r_shadow;
`ifdef CONV_KERNEL_PRESET_EN
    if (i_cfg_preset_ld) begin
      if (r_pending || (SIZE != 3 && i_cfg_preset_sel != 2'd0)) begin
        w_ld_bad = 1'b1;
      end else begin
        w_ld_ok  = 1'b1;
        w_load_k = preset_kernel(i_cfg_preset_sel);
      end
    end else
`endif
    if (i_cfg_wr_en) begin
      if (r_pending || int'(i_cfg_addr) >= NTAPS) begin
        w_ld_bad = 1'b1;
      end else begin
        w_ld_ok = 1'b1;
        for (int r = 0; r < SIZE; r++) begin
          for (int c = 0; c < SIZE; c++) begin
            if (int'(i_cfg_addr) == r * SIZE + c) w_load_k[r][c] = i_cfg_data;
          end
        end
      end
    end
  end

  // Shadow bank: host-visible staging copy, locked while a swap is pending
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow <= reset_kernel();
    end else if (w_ld_ok) begin
      r_shadow <= w_load_k;
    end
  end

  // Sticky error for any rejected shadow load
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_ld_bad) begin
      r_err <= 1'b1;
    end
  end

  // Frame FSM: holds commits until a frame boundary, then copies shadow into active for one cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
      r_active  <= reset_kernel();
      r_swap    <= 1'b0;
    end else begin
      r_swap <= 1'b0;
      if (i_cfg_commit) r_pending <= 1'b1;
      case (r_state)
        IDLE: begin
          if (r_pending)        r_state <= SWAP;
          else if (i_pix_valid) r_state <= RUN;
        end
        RUN: begin
          if (w_last) r_state <= (r_pending || i_cfg_commit) ? SWAP : IDLE;
        end
        SWAP: begin
          r_active  <= r_shadow;
          r_pending <= 1'b0;
          r_swap    <= 1'b1;
          r_state   <= (i_pix_valid || w_in_frame) ? RUN : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_kernel_ctrl.sv
// tb/tb_conv_kernel_ctrl.sv - directed self-checking bench for conv_kernel_ctrl on a reduced 112x8 raster
module tb_conv_kernel_ctrl;
  import conv_pkg::*;

  localparam int LW = 112;
  localparam int FL = 8;

  localparam logic [71:0] K_RST  = 72'h000000000100000000;
  localparam logic [71:0] K_SOB  = 72'hff0001fe0002ff0001;
  localparam logic [71:0] K_LAP  = 72'h00010001fc01000100;
  localparam logic [71:0] K_LAP5 = 72'h05010001fc01000100;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic        cfg_wr_en;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_commit;
  logic        cfg_busy;
  logic        cfg_err;
  logic [71:0] kernel;
  logic [6:0]  frame_x;
  logic [2:0]  frame_y;
  logic        frame_done;
  logic        kernel_swap;
`ifdef CONV_KERNEL_PRESET_EN
  logic        cfg_preset_ld = 1'b0;
  logic [1:0]  cfg_preset_sel = 2'd0;
`endif

  logic [7:0] sob [9] = '{8'hff, 8'h00, 8'h01, 8'hfe, 8'h00, 8'h02, 8'hff, 8'h00, 8'h01};
  logic [7:0] lap [9] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'hfc, 8'h01, 8'h00, 8'h01, 8'h00};

  int   n_vec = 0;
  int   n_bad = 0;
  logic hold_ok;

  conv_kernel_ctrl #(
    .LINE_WIDTH  (LW),
    .FRAME_LINES (FL)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_pix_valid      (pix_valid),
    .i_cfg_wr_en      (cfg_wr_en),
    .i_cfg_addr       (cfg_addr),
    .i_cfg_data       (cfg_data),
    .i_cfg_commit     (cfg_commit),
`ifdef CONV_KERNEL_PRESET_EN
    .i_cfg_preset_ld  (cfg_preset_ld),
    .i_cfg_preset_sel (cfg_preset_sel),
`endif
    .o_cfg_busy       (cfg_busy),
    .o_cfg_err        (cfg_err),
    .o_kernel         (kernel),
    .o_frame_x        (frame_x),
    .o_frame_y        (frame_y),
    .o_frame_done     (frame_done),
    .o_kernel_swap    (kernel_swap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pix(input int n);
    pix_valid = 1'b1;
    for (int i = 0; i < n; i++) tick();
    pix_valid = 1'b0;
  endtask

  task automatic write_tap(input int addr, input logic [7:0] data);
    cfg_wr_en = 1'b1;
    cfg_addr  = 4'(addr);
    cfg_data  = data;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pix_valid = 1'b0; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("rst_kernel", kernel, K_RST);
    check("rst_busy", cfg_busy, 0);
    check("rst_err", cfg_err, 0);
    check("rst_xy", {frame_x, frame_y}, 0);
    check("rst_swap", kernel_swap, 0);

    // IDLE load of Sobel-X then commit
    for (int i = 0; i < 9; i++) write_tap(i, sob[i]);
    check("idle_wr_kernel_held", kernel, K_RST);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    check("idle_busy_after_commit", cfg_busy, 1);
    check("idle_swap_c1", kernel_swap, 0);
    tick();
    check("idle_kernel_c1", kernel, K_RST);
    tick();
    check("idle_swap_c2", kernel_swap, 1);
    check("idle_kernel_c2", kernel, K_SOB);
    check("idle_busy_clear", cfg_busy, 0);
    tick();
    check("idle_swap_pulse", kernel_swap, 0);

    // Stage Laplacian, then commit mid-frame at (10,5) and try a locked write
    for (int i = 0; i < 9; i++) write_tap(i, lap[i]);
    run_pix(5 * LW + 10);
    check("mid_xy", {frame_x, frame_y}, {7'd10, 3'd5});
    pix_valid = 1'b1; cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    cfg_wr_en = 1'b1; cfg_addr = 4'd0; cfg_data = 8'h07; tick(); cfg_wr_en = 1'b0;
    check("busy_wr_err", cfg_err, 1);
    check("mid_busy", cfg_busy, 1);
    hold_ok = 1'b1;
    for (int i = 0; i < LW * FL - 1 - (5 * LW + 12); i++) begin
      tick();
      if (kernel !== K_SOB || cfg_busy !== 1'b1 || kernel_swap !== 1'b0) hold_ok = 1'b0;
    end
    check("mid_hold", hold_ok, 1);
    check("last_xy", {frame_x, frame_y}, {7'd111, 3'd7});
    tick(); pix_valid = 1'b0;
    check("mid_done", frame_done, 1);
    check("mid_done_kernel", kernel, K_SOB);
    check("mid_done_swap", kernel_swap, 0);
    check("mid_wrap_xy", {frame_x, frame_y}, 0);
    tick();
    check("mid_swap", kernel_swap, 1);
    check("mid_done_pulse", frame_done, 0);
    check("mid_kernel_lap", kernel, K_LAP);
    check("mid_busy_clear", cfg_busy, 0);

    // Commit in the same cycle as the last pixel
    write_tap(0, 8'h05);
    run_pix(LW * FL - 1);
    check("lc_last_xy", {frame_x, frame_y}, {7'd111, 3'd7});
    pix_valid = 1'b1; cfg_commit = 1'b1; tick(); pix_valid = 1'b0; cfg_commit = 1'b0;
    check("lc_done", frame_done, 1);
    check("lc_busy", cfg_busy, 1);
    check("lc_kernel_old", kernel, K_LAP);
    tick();
    check("lc_swap", kernel_swap, 1);
    check("lc_kernel_new", kernel, K_LAP5);
    check("lc_xy", {frame_x, frame_y}, 0);

    // Reset mid-frame at (100,6) with a commit pending
    run_pix(6 * LW + 100);
    check("rm_xy", {frame_x, frame_y}, {7'd100, 3'd6});
    pix_valid = 1'b1; cfg_commit = 1'b1; tick(); pix_valid = 1'b0; cfg_commit = 1'b0;
    check("rm_busy", cfg_busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rm_xy_zero", {frame_x, frame_y}, 0);
    check("rm_busy_zero", cfg_busy, 0);
    check("rm_kernel", kernel, K_RST);
    check("rm_err_cleared", cfg_err, 0);
    hold_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (kernel_swap !== 1'b0 || kernel !== K_RST) hold_ok = 1'b0;
    end
    check("rm_no_swap", hold_ok, 1);

    // Out-of-range address is rejected and leaves the shadow bank intact
    write_tap(9, 8'h05);
    check("addr9_err", cfg_err, 1);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    tick(); tick();
    check("addr9_swap", kernel_swap, 1);
    check("addr9_kernel", kernel, K_RST);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
